fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Serial-to-parallel front end for the 8-point FFT core `top`. It accepts complex samples one per beat over a valid/ready stream and packs each frame of `N` samples into the `N*WIDTH`-bit `input_data` vector. It drives `start` into the core and holds the frame stable until the core reports `done`. Two frame banks (ping-pong) let the next frame fill while the core processes the current one.

## Interface
- `N`, 8, samples per frame (power of two, ≥2)
- `WIDTH`, 32, bits per complex sample: [WIDTH-1:WIDTH/2] real FP16, [WIDTH/2-1:0] imaginary FP16
- `clk` input 1: single clock, rising edge
- `reset_n` input 1: reset, asynchronous, active-low
- `s_data` input WIDTH: sample beat
- `s_valid` input 1: `s_data` valid
- `s_ready` output 1: loader can accept a beat
- `s_last` input 1: marks final beat of a frame (checked only with `LOADER_FRAME_CHECK_EN`)
- `frame_data` output N*WIDTH: to `top.input_data`
- `start` output 1: to `top.start`
- `fft_done` input 1: from `top.done`
- `frame_err` output 1: one-cycle pulse on frame-sync error

## Operation
- Beat accepted when `s_valid && s_ready` at a rising edge.
- Beat index i (0..N-1) writes fill bank bits [N*WIDTH-1-i*WIDTH -: WIDTH], so sample 0 occupies the MSBs.
- Index wraps to 0 after beat N-1. The fill bank is then marked full.
- Bank state per bank: EMPTY → FILLING → FULL → LAUNCHED → EMPTY.
- Loader state machine:
  - IDLE: no bank launched.
  - RUN: `start`=1, launched bank driven on `frame_data`.
  - DRAIN: one cycle with `start`=0 after `fft_done`.
- IDLE→RUN when a bank is FULL. The bank becomes LAUNCHED and `sel` points to it.
- RUN→DRAIN when `fft_done` is sampled 1. The launched bank returns to EMPTY.
- DRAIN→RUN if the other bank is FULL, otherwise DRAIN→IDLE.
- `s_ready` = 1 iff the bank not LAUNCHED/FULL is available for filling and the loader is not in reset.
- `frame_data` is registered. It changes only on entry to RUN and is held constant for the whole RUN.
- `fft_done` outside RUN is ignored.
- Simultaneous events:
  - Last beat accepted while `fft_done` is sampled: both take effect. DRAIN, then RUN with the new bank.
  - Both banks FULL cannot occur with one LAUNCHED. In that case `s_ready`=0.
- Reset asserted at any time:
  - All state and banks clear asynchronously. `start`, `s_ready`, `frame_err`, `frame_data` go to 0.
  - After release, `s_ready` rises at the first clock edge and filling restarts at index 0.

## Timing
- Reset values: `s_ready`=0, `start`=0, `frame_err`=0, `frame_data`=0.
- Launch latency: last beat accepted at edge k with the loader in IDLE → `start`=1 and `frame_data` valid from edge k+1.
- `fft_done` sampled at edge d → `start`=0 from edge d. The earliest relaunch is edge d+1, so `start` is low for at least one cycle between frames.
- Throughput: one beat per cycle while a bank is free.
- `s_ready` deasserts at the edge that accepts beat N-1 when the other bank is LAUNCHED. It reasserts at the edge where that bank is freed.

## Configuration
- `LOADER_FRAME_CHECK_EN` defined:
  - `s_last`=1 on index ≠ N-1, or `s_last`=0 on index N-1, pulses `frame_err` for one cycle.
  - The partial frame is discarded: bank cleared, index reset to 0.
  - The offending beat is dropped. No launch occurs.
- Not defined:
  - `s_last` is ignored and `frame_err` is tied 0.
  - Frames are delimited purely by counting N beats.

## Test plan
1. Reset, then 8 beats 0x3C000000, 0x40000000, 0x42000000, 0x44000000, 0x44000000, 0x42000000, 0x40000000, 0x3C000000 with `s_last` on beat 7.
   - Required: `frame_data`=256'h3c000000400000004200000044000000440000004200000040000000 3c000000 (no space), and `start`=1 one cycle after beat 7.
2. Two back-to-back frames, `fft_done` pulsed 50 cycles after the first launch.
   - Required: `s_ready`=0 after the 16th beat.
   - Required: `start` low exactly one cycle after `fft_done`, then high with frame 2 data.
   - Required: `s_ready`=1 again.
3. `s_last` on beat 3, then 8 clean beats.
   - With macro: `frame_err` pulses once, the first partial frame never launches, and the clean frame launches correctly.
   - Without macro: 8 beats are counted from the first beat.
4. Last beat of bank B accepted in the same cycle `fft_done` is sampled.
   - Required: `start` 0 for one cycle, then 1 with bank B contents, with no beat lost.
5. Assert `reset_n`=0 mid-fill and again during RUN.
   - Required: `start`, `s_ready`, `frame_data` go to 0 immediately.
   - Required: after release, `s_ready` rises at the first edge and a fresh 8-beat frame launches normally.

Source files
------------

// File: rtl/fft_frame_loader.sv
// Ping-pong serial-to-parallel loader feeding an N-point FFT core with start/done handshake.
// Optional build macro LOADER_FRAME_CHECK_EN enables s_last frame-sync checking and frame_err.
module fft_frame_loader #(
    parameter int N     = 8,
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_last,
    output logic [N*WIDTH-1:0]   frame_data,
    output logic                 start,
    input  logic                 fft_done,
    output logic                 frame_err,
    output logic [1:0]           dbg_state
);

    // Stream handshake: a beat transfers on a rising edge where s_valid && s_ready;
    // s_valid/s_data/s_last are held by the source until then, s_ready is a registered flag.
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_LAUNCHED} bank_st_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} ld_st_t;

    logic [N*WIDTH-1:0] bank_q    [2];
    logic [N*WIDTH-1:0] bank_d    [2];
    bank_st_t           bank_st_q [2];
    bank_st_t           bank_st_d [2];
    ld_st_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               fill_q, fill_d;
    logic               sel_q, sel_d;
    logic               start_q, start_d;
    logic               s_ready_q, s_ready_d;
    logic               frame_err_q, frame_err_d;
    logic [N*WIDTH-1:0] frame_data_q, frame_data_d;

    logic accept;
    logic last_beat;
    logic sync_err;
    logic launch;
    logic launch_sel;

    assign accept    = s_valid && s_ready_q;
    assign last_beat = (idx_q == IW'(N - 1));

`ifdef LOADER_FRAME_CHECK_EN
    assign sync_err = accept && (s_last != last_beat);
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign sync_err      = 1'b0;
`endif

    always_comb begin
        bank_d       = bank_q;
        bank_st_d    = bank_st_q;
        state_d      = state_q;
        idx_d        = idx_q;
        fill_d       = fill_q;
        sel_d        = sel_q;
        start_d      = start_q;
        frame_data_d = frame_data_q;
        frame_err_d  = 1'b0;
        launch       = 1'b0;
        launch_sel   = 1'b0;

        // A sync error throws away the partial frame together with the offending beat.
        if (sync_err) begin
            bank_d[fill_q]    = '0;
            bank_st_d[fill_q] = B_EMPTY;
            idx_d             = '0;
            frame_err_d       = 1'b1;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (idx_q == IW'(i)) begin
                    bank_d[fill_q][(N-1-i)*WIDTH +: WIDTH] = s_data;
                end
            end
            if (last_beat) begin
                bank_st_d[fill_q] = B_FULL;
                idx_d             = '0;
                fill_d            = ~fill_q;
            end else begin
                bank_st_d[fill_q] = B_FILLING;
                idx_d             = idx_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bank_st_q[0] == B_FULL) begin
                    launch     = 1'b1;
                    launch_sel = 1'b0;
                end else if (bank_st_q[1] == B_FULL) begin
                    launch     = 1'b1;
                    launch_sel = 1'b1;
                end
            end
            S_RUN: begin
                if (fft_done) begin
                    bank_st_d[sel_q] = B_EMPTY;
                    start_d          = 1'b0;
                    state_d          = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bank_st_q[~sel_q] == B_FULL) begin
                    launch     = 1'b1;
                    launch_sel = ~sel_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A launched bank is never the fill bank, so this cannot collide with the write above.
        if (launch) begin
            sel_d                 = launch_sel;
            bank_st_d[launch_sel] = B_LAUNCHED;
            start_d               = 1'b1;
            frame_data_d          = bank_q[launch_sel];
            state_d               = S_RUN;
        end

        s_ready_d = (bank_st_d[fill_d] == B_EMPTY) || (bank_st_d[fill_d] == B_FILLING);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b]    <= '0;
                bank_st_q[b] <= B_EMPTY;
            end
            state_q      <= S_IDLE;
            idx_q        <= '0;
            fill_q       <= 1'b0;
            sel_q        <= 1'b0;
            start_q      <= 1'b0;
            s_ready_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_data_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b]    <= bank_d[b];
                bank_st_q[b] <= bank_st_d[b];
            end
            state_q      <= state_d;
            idx_q        <= idx_d;
            fill_q       <= fill_d;
            sel_q        <= sel_d;
            start_q      <= start_d;
            s_ready_q    <= s_ready_d;
            frame_err_q  <= frame_err_d;
            frame_data_q <= frame_data_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign start      = start_q;
    assign frame_err  = frame_err_q;
    assign frame_data = frame_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader (N=8, WIDTH=32).
module tb_fft_frame_loader;

    logic         clk;
    logic         reset_n;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [255:0] frame_data;
    logic         start;
    logic         fft_done;
    logic         frame_err;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_errors;
    logic [31:0] vec [16];

    fft_frame_loader #(.N(8), .WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_last     (s_last),
        .frame_data (frame_data),
        .start      (start),
        .fft_done   (fft_done),
        .frame_err  (frame_err),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_of(input int lo);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], vec[lo+i]};
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("beat_timeout", 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_range(input int lo, input int cnt, input int last_rel);
        for (int j = 0; j < cnt; j++) send_beat(vec[lo+j], ((j % 8) == last_rel));
    endtask

    task automatic expect_launch(input string tag, input int lo);
        check({tag, "_not_early"}, start, 1'b0);
        @(negedge clk);
        check({tag, "_start"}, start, 1'b1);
        check({tag, "_data"}, frame_data, exp_of(lo));
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
    endtask

    task automatic load_vec(input logic [15:0] tag);
        for (int i = 0; i < 16; i++) vec[i] = {tag + 16'(i), 16'hC000 + 16'(i)};
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        fft_done = 1'b0;

        // Reset values and first-edge s_ready rise
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_frame_data", frame_data, 256'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_s_ready", s_ready, 1'b1);

        // Test 1: the reference frame
        vec[0] = 32'h3C000000; vec[1] = 32'h40000000; vec[2] = 32'h42000000; vec[3] = 32'h44000000;
        vec[4] = 32'h44000000; vec[5] = 32'h42000000; vec[6] = 32'h40000000; vec[7] = 32'h3C000000;
        send_range(0, 8, 7);
        expect_launch("t1", 0);
        check("t1_literal", frame_data,
              256'h3c0000004000000042000000440000004400000042000000400000003c000000);
        pulse_done();
        check("t1_done_low", start, 1'b0);
        @(negedge clk);
        check("t1_idle_low", start, 1'b0);

        // Test 2: back-to-back frames, done ~50 cycles after first launch
        load_vec(16'h4100);
        send_range(0, 16, 7);
        check("t2_ready_low", s_ready, 1'b0);
        check("t2_run_a", start, 1'b1);
        repeat (42) @(negedge clk);
        check("t2_hold_start", start, 1'b1);
        check("t2_hold_data", frame_data, exp_of(0));
        pulse_done();
        check("t2_drain_low", start, 1'b0);
        check("t2_ready_back", s_ready, 1'b1);
        @(negedge clk);
        check("t2_relaunch", start, 1'b1);
        check("t2_data_b", frame_data, exp_of(8));
        pulse_done();
        check("t2_done_low", start, 1'b0);
        @(negedge clk);
        check("t2_idle_low", start, 1'b0);

        // Test 3: s_last on beat 3, then a clean frame
        load_vec(16'h4200);
`ifdef LOADER_FRAME_CHECK_EN
        send_range(0, 4, 3);
        check("t3_err_pulse", frame_err, 1'b1);
        send_beat(vec[4], 1'b0);
        check("t3_err_once", frame_err, 1'b0);
        send_range(5, 7, 6);
        expect_launch("t3", 4);
        pulse_done();
        check("t3_done_low", start, 1'b0);
        @(negedge clk);
`else
        send_range(0, 4, 3);
        send_range(4, 8, 7);
        check("t3_no_err", frame_err, 1'b0);
        check("t3_start", start, 1'b1);
        check("t3_data", frame_data, exp_of(0));
        pulse_done();
        check("t3_done_low", start, 1'b0);
        send_range(12, 4, 3);
        expect_launch("t3b", 8);
        pulse_done();
        @(negedge clk);
`endif

        // Test 4: last beat of second bank accepted with fft_done
        load_vec(16'h4300);
        send_range(0, 8, 7);
        expect_launch("t4a", 0);
        send_range(8, 7, 7);
        s_data   = vec[15];
        s_last   = 1'b1;
        s_valid  = 1'b1;
        fft_done = 1'b1;
        check("t4_ready_pre", s_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        s_valid  = 1'b0;
        s_last   = 1'b0;
        fft_done = 1'b0;
        check("t4_gap_low", start, 1'b0);
        check("t4_ready", s_ready, 1'b1);
        @(negedge clk);
        check("t4_start_b", start, 1'b1);
        check("t4_data_b", frame_data, exp_of(8));
        pulse_done();
        @(negedge clk);

        // Test 5: reset mid-fill, then during RUN
        load_vec(16'h4400);
        send_range(0, 3, 7);
        reset_n = 1'b0;
        #1;
        check("t5a_start", start, 1'b0);
        check("t5a_ready", s_ready, 1'b0);
        check("t5a_data", frame_data, 256'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("t5a_ready_held", s_ready, 1'b0);
        @(negedge clk);
        check("t5a_ready_rise", s_ready, 1'b1);
        send_range(0, 8, 7);
        expect_launch("t5a", 0);
        reset_n = 1'b0;
        #1;
        check("t5b_start", start, 1'b0);
        check("t5b_ready", s_ready, 1'b0);
        check("t5b_data", frame_data, 256'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t5b_ready_rise", s_ready, 1'b1);
        send_range(8, 8, 7);
        expect_launch("t5b", 8);
        pulse_done();
        check("t5b_done_low", start, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
